dtw_pair_sequencer_8f: RTL and testbench

//  Source end of the 8-feature distance interface. Buffers a template sequence and a test sequence of packed
//  32-bit feature words (8 x 4-bit signed features). Streams every (test i, template j) pair to the distance unit,
//  one pair per cycle, test-major. Re-aligns the returned distance with its (i,j) tag and emits it to the DTW matrix.

---
 rtl/dtw_pkg.sv | 32 +++
 rtl/dtw_pair_sequencer_8f_if.sv | 27 ++
 rtl/dtw_tag_delay.sv | 38 +++
 rtl/dtw_pair_sequencer_8f.sv | 201 ++++++++++++++++++++
 tb/tb_dtw_pair_sequencer_8f.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtw_pkg.sv
// Shared types and sizes for the DTW pair sequencer and the DTW matrix block.
package dtw_pkg;

    localparam int N     = 32;  // packed feature word: 8 x 4-bit signed features
    localparam int M     = 8;   // distance width returned by the distance unit
    localparam int DEPTH = 64;  // words per sequence buffer
    localparam int AW    = 6;   // buffer address width
    localparam int LAT   = 4;   // distance-unit latency, pair_valid -> dist_in

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_t;

    // Tag that follows each pair through the distance unit.
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] i;
        logic [AW-1:0] j;
        logic          last;
    } tag_t;

    // Lengths above the buffer depth are treated as a full buffer.
    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        return (len > DEPTH_L) ? DEPTH_L : len;
    endfunction

endpackage

// File: rtl/dtw_pair_sequencer_8f_if.sv
// Pair/distance bus between the sequencer and the 8-feature distance unit.
// Handshake: pair_valid qualifies template_data/test_data in the same cycle and
// there is no ready -- the distance unit must take one pair per cycle. dist_in
// is not qualified on the wire; it is valid exactly LAT cycles after the
// pair_valid of the pair it belongs to.
interface dtw_pair_sequencer_8f_if;

    logic [dtw_pkg::N-1:0] template_data;
    logic [dtw_pkg::N-1:0] test_data;
    logic                  pair_valid;
    logic [dtw_pkg::M-1:0] dist_in;

    modport master (
        output template_data,
        output test_data,
        output pair_valid,
        input  dist_in
    );

    modport slave (
        input  template_data,
        input  test_data,
        input  pair_valid,
        output dist_in
    );

endinterface

// File: rtl/dtw_tag_delay.sv
// Fixed-length shift register carrying {valid, i, j, last} alongside the
// distance unit so each returned distance can be re-aligned with its indices.
module dtw_tag_delay
    import dtw_pkg::*;
#(
    parameter int STAGES = LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [STAGES];
    tag_t stage_d [STAGES];

    // Next value of every stage: shift by one position each cycle.
    always_comb begin
        stage_d[0] = tag_in;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Stage registers; reset discards every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/dtw_pair_sequencer_8f.sv
// Source end of the 8-feature distance interface: buffers a template and a
// test sequence, streams every (test i, template j) pair test-major one per
// cycle, and re-tags the returned distances for the DTW matrix.
module dtw_pair_sequencer_8f
    import dtw_pkg::*;
#(
    parameter int LAT_CYC = LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [AW-1:0]             wr_addr,
    input  logic [N-1:0]              wr_data,
    input  logic [AW:0]               tmpl_len,
    input  logic [AW:0]               test_len,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      dist_valid,
    output logic [M-1:0]              dist_out,
    output logic [AW-1:0]             dist_i,
    output logic [AW-1:0]             dist_j,
    output logic                      dist_last,
    output seq_state_t                dbg_state,
    dtw_pair_sequencer_8f_if.master   dist_bus
);

    // Sequence buffers (contents survive reset).
    logic [N-1:0] tmpl_mem [DEPTH];
    logic [N-1:0] test_mem [DEPTH];

    seq_state_t    state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW:0]   tlen_q, tlen_d;   // test length
    logic [AW:0]   mlen_q, mlen_d;   // template length
    tag_t          pair_tag_q, pair_tag_d;
    logic [N-1:0]  tmpl_rd_q, tmpl_rd_d;
    logic [N-1:0]  test_rd_q, test_rd_d;
    logic          dist_valid_q, dist_valid_d;
    logic [M-1:0]  dist_out_q, dist_out_d;
    logic [AW-1:0] dist_i_q, dist_i_d;
    logic [AW-1:0] dist_j_q, dist_j_d;
    logic          dist_last_q, dist_last_d;

    logic [AW:0]   tlen_c, mlen_c;
    logic          j_end, i_end, last_pair;
    tag_t          tag_exit;

    assign tlen_c    = clamp_len(test_len);
    assign mlen_c    = clamp_len(tmpl_len);
    assign j_end     = ({1'b0, j_q} == (mlen_q - 1'b1));
    assign i_end     = ({1'b0, i_q} == (tlen_q - 1'b1));
    assign last_pair = i_end && j_end;

    // Buffer writes are only honoured while idle so a run sees stable data.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            if (wr_sel) begin
                test_mem[wr_addr] <= wr_data;
            end else begin
                tmpl_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Next-state logic: FSM, index counters, buffer reads and distance re-tagging.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        i_d          = i_q;
        j_d          = j_q;
        tlen_d       = tlen_q;
        mlen_d       = mlen_q;
        pair_tag_d   = '0;
        tmpl_rd_d    = tmpl_rd_q;
        test_rd_d    = test_rd_q;
        dist_valid_d = tag_exit.valid;
        dist_out_d   = dist_out_q;
        dist_i_d     = dist_i_q;
        dist_j_d     = dist_j_q;
        dist_last_d  = dist_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tlen_d  = tlen_c;
                    mlen_d  = mlen_c;
                    i_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ((tlen_c != '0) && (mlen_c != '0)) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                // Issue (i, j): the read registers and the pair tag load together,
                // so pair_valid lines up with the read data one cycle later.
                pair_tag_d.valid = 1'b1;
                pair_tag_d.i     = i_q;
                pair_tag_d.j     = j_q;
                pair_tag_d.last  = last_pair;
                tmpl_rd_d        = tmpl_mem[j_q];
                test_rd_d        = test_mem[i_q];
                if (j_end) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                if (last_pair) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last tag leaving the pipeline is the last distance being registered.
                if (tag_exit.valid && tag_exit.last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tag_exit.valid) begin
            dist_out_d  = dist_bus.dist_in;
            dist_i_d    = tag_exit.i;
            dist_j_d    = tag_exit.j;
            dist_last_d = tag_exit.last;
        end
    end

    // All control and output registers; reset returns to IDLE with outputs at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            tlen_q       <= '0;
            mlen_q       <= '0;
            pair_tag_q   <= '0;
            tmpl_rd_q    <= '0;
            test_rd_q    <= '0;
            dist_valid_q <= 1'b0;
            dist_out_q   <= '0;
            dist_i_q     <= '0;
            dist_j_q     <= '0;
            dist_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            i_q          <= i_d;
            j_q          <= j_d;
            tlen_q       <= tlen_d;
            mlen_q       <= mlen_d;
            pair_tag_q   <= pair_tag_d;
            tmpl_rd_q    <= tmpl_rd_d;
            test_rd_q    <= test_rd_d;
            dist_valid_q <= dist_valid_d;
            dist_out_q   <= dist_out_d;
            dist_i_q     <= dist_i_d;
            dist_j_q     <= dist_j_d;
            dist_last_q  <= dist_last_d;
        end
    end

    dtw_tag_delay #(
        .STAGES (LAT_CYC)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (pair_tag_q),
        .tag_out (tag_exit)
    );

    assign dist_bus.template_data = tmpl_rd_q;
    assign dist_bus.test_data     = test_rd_q;
    assign dist_bus.pair_valid    = pair_tag_q.valid;

    assign busy       = busy_q;
    assign done       = done_q;
    assign dist_valid = dist_valid_q;
    assign dist_out   = dist_out_q;
    assign dist_i     = dist_i_q;
    assign dist_j     = dist_j_q;
    assign dist_last  = dist_last_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dtw_pair_sequencer_8f.sv
// Self-checking bench for dtw_pair_sequencer_8f with a loopback distance unit.
module tb_dtw_pair_sequencer_8f;
    import dtw_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic [AW:0]   tmpl_len;
    logic [AW:0]   test_len;
    logic          start;
    logic          busy;
    logic          done;
    logic          dist_valid;
    logic [M-1:0]  dist_out;
    logic [AW-1:0] dist_i;
    logic [AW-1:0] dist_j;
    logic          dist_last;
    seq_state_t    dbg_state;

    dtw_pair_sequencer_8f_if bus ();

    dtw_pair_sequencer_8f dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .tmpl_len   (tmpl_len),
        .test_len   (test_len),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .dist_valid (dist_valid),
        .dist_out   (dist_out),
        .dist_i     (dist_i),
        .dist_j     (dist_j),
        .dist_last  (dist_last),
        .dbg_state  (dbg_state),
        .dist_bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench copy of the buffer contents.
    logic [N-1:0] tmpl_m [DEPTH];
    logic [N-1:0] test_m [DEPTH];

    // Scoreboard queues.
    logic [2*N-1:0]         exp_pair_q [$];
    logic [1+2*AW+M-1:0]    exp_q [$];
    int                     pv_cyc_q [$];

    function automatic logic [M-1:0] dist_f(input logic [N-1:0] te, input logic [N-1:0] tm);
        logic [7:0] a;
        logic [7:0] b;
        a = te[7:0];
        b = tm[7:0];
        return 8'((a << 3) + b);
    endfunction

    // Loopback distance unit: LAT-cycle pipeline from the pair bus to dist_in.
    logic [M-1:0] dpipe [LAT];
    initial begin
        for (int k = 0; k < LAT; k++) dpipe[k] = '0;
    end
    always @(posedge clk) begin
        dpipe[0] <= bus.pair_valid ? dist_f(bus.test_data, bus.template_data) : '0;
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign bus.dist_in = dpipe[LAT-1];

    // Driver: one buffer write while idle.
    task automatic write_word(input logic sel, input int addr, input logic [N-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) test_m[addr] = data;
        else     tmpl_m[addr] = data;
    endtask

    // Driver + scoreboard for one run. inj_cyc >= 1 pulses start and a template
    // write during that cycle of the run.
    task automatic do_run(input int tl, input int ml, input int budget, input int inj_cyc,
                          output int n_pv, output int n_dv, output int first_pv,
                          output int last_pv, output int last_dv, output int done_cyc);
        logic [2*N-1:0]      pexp;
        logic [1+2*AW+M-1:0] dexp;
        logic [1+2*AW+M-1:0] dgot;
        logic                lst;
        int                  pcyc;
        int                  cyc;
        bit                  seen_done;
        n_pv = 0; n_dv = 0; first_pv = -1; last_pv = -1; last_dv = -1; done_cyc = -1;
        seen_done = 1'b0;
        exp_pair_q.delete();
        exp_q.delete();
        pv_cyc_q.delete();
        for (int i = 0; i < tl; i++) begin
            for (int j = 0; j < ml; j++) begin
                lst = (i == tl - 1) && (j == ml - 1);
                exp_pair_q.push_back({test_m[i], tmpl_m[j]});
                exp_q.push_back({lst, AW'(i), AW'(j), dist_f(test_m[i], tmpl_m[j])});
            end
        end
        @(negedge clk);
        test_len = (AW+1)'(tl);
        tmpl_len = (AW+1)'(ml);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!seen_done && cyc <= budget) begin
            if (bus.pair_valid === 1'b1) begin
                n_pv++;
                if (first_pv < 0) first_pv = cyc;
                last_pv = cyc;
                pv_cyc_q.push_back(cyc);
                checks++;
                if (exp_pair_q.size() == 0) begin
                    errors++;
                    $display("FAIL pair_extra: cycle %0d got test=%h tmpl=%h, none expected",
                             cyc, bus.test_data, bus.template_data);
                end else begin
                    pexp = exp_pair_q.pop_front();
                    if ({bus.test_data, bus.template_data} !== pexp || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL pair_data: cycle %0d got %h busy=%b, expected %h busy=1",
                                 cyc, {bus.test_data, bus.template_data}, busy, pexp);
                    end
                end
            end
            if (dist_valid === 1'b1) begin
                n_dv++;
                last_dv = cyc;
                dgot = {dist_last, dist_i, dist_j, dist_out};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dist_extra: cycle %0d got %h, none expected", cyc, dgot);
                end else begin
                    dexp = exp_q.pop_front();
                    if (dgot !== dexp) begin
                        errors++;
                        $display("FAIL dist_tag: cycle %0d got last/i/j/dist=%h, expected %h",
                                 cyc, dgot, dexp);
                    end
                end
                checks++;
                if (pv_cyc_q.size() == 0) begin
                    errors++;
                    $display("FAIL dist_latency: cycle %0d dist with no earlier pair", cyc);
                end else begin
                    pcyc = pv_cyc_q.pop_front();
                    if (cyc - pcyc != LAT + 1) begin
                        errors++;
                        $display("FAIL dist_latency: got %0d cycles, expected %0d", cyc - pcyc, LAT + 1);
                    end
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
            if (cyc == inj_cyc) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = '0;
                wr_data = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: after done got done=%b busy=%b, expected 0 0", done, busy);
        end
        checks++;
        if (exp_q.size() != 0 || exp_pair_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d dists and %0d pairs never seen", exp_q.size(), exp_pair_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        tmpl_len = '0; test_len = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dist_valid, dist_last, bus.pair_valid} !== 5'b0 ||
            {dist_out, dist_i, dist_j} !== '0 || {bus.template_data, bus.test_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b dv=%b pv=%b dout=%h, expected all 0",
                     busy, done, dist_valid, bus.pair_valid, dist_out);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected IDLE", dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_pairs();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        write_word(1'b0, 0, 32'h11111111);
        write_word(1'b0, 1, 32'h22222222);
        write_word(1'b1, 0, 32'h33333333);
        do_run(1, 2, 40, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 2 || n_dv != 2) begin
            errors++;
            $display("FAIL two_pairs_count: got pv=%0d dv=%0d, expected 2 2", n_pv, n_dv);
        end
        checks++;
        if (fpv != 2) begin
            errors++;
            $display("FAIL two_pairs_first: got cycle %0d, expected 2", fpv);
        end
        checks++;
        if (dcyc != ldv + 1) begin
            errors++;
            $display("FAIL two_pairs_done: got cycle %0d, expected %0d", dcyc, ldv + 1);
        end
    endtask

    task automatic test_order();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        for (int k = 0; k < 3; k++) write_word(1'b0, k, $urandom_range(32'h7FFFFFFF, 0));
        for (int k = 0; k < 2; k++) write_word(1'b1, k, $urandom_range(32'h7FFFFFFF, 0));
        do_run(2, 3, 60, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 6 || lpv - fpv != 5) begin
            errors++;
            $display("FAIL order_burst: got %0d pairs over %0d cycles, expected 6 over 6",
                     n_pv, lpv - fpv + 1);
        end
    endtask

    task automatic test_zero_len();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        do_run(5, 0, 20, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 0 || n_dv != 0) begin
            errors++;
            $display("FAIL zero_len_traffic: got pv=%0d dv=%0d, expected 0 0", n_pv, n_dv);
        end
        checks++;
        if (dcyc != 2) begin
            errors++;
            $display("FAIL zero_len_done: got cycle %0d, expected 2", dcyc);
        end
    endtask

    task automatic test_single();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        do_run(1, 1, 30, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 1 || n_dv != 1) begin
            errors++;
            $display("FAIL single_count: got pv=%0d dv=%0d, expected 1 1", n_pv, n_dv);
        end
    endtask

    task automatic test_busy_writes();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        for (int k = 0; k < 2; k++) write_word(1'b0, k, $urandom_range(32'h7FFFFFFF, 0));
        for (int k = 0; k < 2; k++) write_word(1'b1, k, $urandom_range(32'h7FFFFFFF, 0));
        do_run(2, 2, 40, 3, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 4 || n_dv != 4) begin
            errors++;
            $display("FAIL busy_run: got pv=%0d dv=%0d, expected 4 4", n_pv, n_dv);
        end
        // Second run reads the buffers back against the unchanged bench copy.
        do_run(2, 2, 40, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 4) begin
            errors++;
            $display("FAIL busy_readback: got pv=%0d, expected 4", n_pv);
        end
    endtask

    task automatic test_reset_mid();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        bit seen;
        for (int k = 0; k < 4; k++) write_word(1'b0, k, $urandom_range(32'h7FFFFFFF, 0));
        for (int k = 0; k < 4; k++) write_word(1'b1, k, $urandom_range(32'h7FFFFFFF, 0));
        @(negedge clk);
        tmpl_len = 7'd4; test_len = 7'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, dist_valid, dist_last, bus.pair_valid} !== 5'b0 ||
            {dist_out, dist_i, dist_j} !== '0 || {bus.template_data, bus.test_data} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b dv=%b pv=%b, expected all 0",
                     busy, done, dist_valid, bus.pair_valid);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL midrst_state: got %0d, expected IDLE", dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (done === 1'b1 || dist_valid === 1'b1 || bus.pair_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_quiet: got activity after reset, expected none");
        end
        do_run(4, 4, 60, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_pv != 16 || n_dv != 16) begin
            errors++;
            $display("FAIL midrst_rerun: got pv=%0d dv=%0d, expected 16 16", n_pv, n_dv);
        end
    endtask

    task automatic test_loopback_64();
        int n_pv, n_dv, fpv, lpv, ldv, dcyc;
        for (int k = 0; k < DEPTH; k++) write_word(1'b0, k, N'(k));
        for (int k = 0; k < DEPTH; k++) write_word(1'b1, k, N'(k));
        do_run(64, 64, 4200, -1, n_pv, n_dv, fpv, lpv, ldv, dcyc);
        checks++;
        if (n_dv != 4096 || lpv - fpv != 4095) begin
            errors++;
            $display("FAIL loop64_count: got dv=%0d span=%0d, expected 4096 4095", n_dv, lpv - fpv);
        end
    endtask

    initial begin
        test_reset();
        test_two_pairs();
        test_order();
        test_zero_len();
        test_single();
        test_busy_writes();
        test_reset_mid();
        test_loopback_64();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
